// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: fetches 32-bit words over a req/ack memory port,
// buffers {word, pc} pairs in a small FIFO and serves them over valid/ready.
// A redirect flushes the FIFO and restarts fetching at the new target. A
// response that is still in flight when the redirect arrives is discarded.
module instr_prefetch_unit #(
  parameter int                 ADDR_W   = 64,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    WAIT = 2'd1,  // outstanding, response will be kept
    DROP = 2'd2   // outstanding, response will be discarded
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push;
  logic                pop;

  // FIFO storage; no reset needed because count gates every read.
  logic [31:0]         word_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];

  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? word_mem[head_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[head_q]   : '0;
  assign imem_req    = (state_q != IDLE);

  // Address shown to memory: the dropped request keeps its original address.
  always_comb begin
    imem_addr = '0;
    case (state_q)
      WAIT:    imem_addr = fetch_pc_q;
      DROP:    imem_addr = drop_addr_q;
      default: imem_addr = '0;
    endcase
  end

  // Next-state logic: redirect flushes everything and overrides push/pop.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      case (state_q)
        WAIT: begin
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            // Hold the old address on the bus until memory answers.
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
          end
        end
        DROP:    if (imem_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      pop  = instr_valid && instr_ready;
      push = (state_q == WAIT) && imem_ack;
      if (pop) head_d = head_q + PTR_W'(1);
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        IDLE:    if (count_q < CNT_W'(DEPTH)) state_d = WAIT;
        WAIT:    if (imem_ack) state_d = (count_d < CNT_W'(DEPTH)) ? WAIT : IDLE;
        DROP:    if (imem_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Write the accepted memory word and its PC at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: a variable-latency memory responder, a
// queue-based model of the fetch stream checked every cycle, and directed
// scenarios with hand-computed expectations.
module tb_instr_prefetch_unit;

  localparam int ADDR_W = 64;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = 32'h0;
  logic              instr_valid;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  instr_prefetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: each address gives a distinct word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory responder ----------------
  int lat = 0;
  int wait_cnt = 0;
  logic [ADDR_W-1:0] req_log[$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) wait_cnt = 0;
    else if (imem_req && imem_ack) wait_cnt = 0;
    else if (imem_req) wait_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
    end else begin
      if (imem_req && wait_cnt == 0) req_log.push_back(imem_addr);
      imem_ack = imem_req && (wait_cnt >= lat);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0]       w;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  ent_t              mq[$];        // words the consumer will see, in order
  logic              m_out = 1'b0; // a request is on the bus
  logic              m_keep = 1'b0;// its answer will be delivered
  logic [ADDR_W-1:0] m_out_addr = '0;
  logic [ADDR_W-1:0] m_next = '0;  // where the next kept fetch goes

  initial forever begin
    int  pre_n;
    logic start;
    ent_t e;
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_out = 1'b0; m_keep = 1'b0; m_out_addr = '0; m_next = '0;
    end else begin
      pre_n = mq.size();
      start = 1'b0;
      if (redirect) begin
        mq.delete();
        m_next = redirect_pc;
        if (m_out) begin
          if (imem_ack) m_out = 1'b0;
          else m_keep = 1'b0;
        end
      end else begin
        if (instr_ready && pre_n > 0) begin
          e = mq.pop_front();
          $display("pop pc=%h instr=%h", e.pc, e.w);
        end
        if (m_out && imem_ack) begin
          m_out = 1'b0;
          if (m_keep) begin
            e.w = imem_rdata; e.pc = m_out_addr;
            mq.push_back(e);
            m_next = m_out_addr + 64'd4;
            if (mq.size() < DEPTH) start = 1'b1;
          end
        end else if (!m_out && pre_n < DEPTH) begin
          start = 1'b1;
        end
      end
      if (start) begin
        m_out = 1'b1; m_keep = 1'b1; m_out_addr = m_next;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic exp_v;
    @(negedge clk);
    if (!reset) begin
      exp_v = (mq.size() > 0);
      check("imem_req",    64'(imem_req),    64'(m_out));
      check("imem_addr",   imem_addr,        m_out ? m_out_addr : 64'h0);
      check("instr_valid", 64'(instr_valid), 64'(exp_v));
      check("instruction", 64'(instruction), exp_v ? 64'(mq[0].w) : 64'h0);
      check("instr_pc",    instr_pc,         exp_v ? mq[0].pc : 64'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    req_log.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    int L;

    // 1: zero-wait memory, consumer always ready
    lat = 0;
    do_reset();
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_valid", 64'(instr_valid), 64'd1);
    check("t1_pc0",   instr_pc, 64'h0);
    check("t1_word0", 64'(instruction), 64'h0000_FFFF);
    check("t1_addr",  imem_addr, 64'h4);
    repeat (10) @(negedge clk);
    check("t1_log0", req_log[0], 64'h0);
    check("t1_log1", req_log[1], 64'h4);
    check("t1_log2", req_log[2], 64'h8);
    check("t1_log3", req_log[3], 64'hC);

    // 2: consumer stalled, slow memory fills the FIFO
    lat = 2;
    do_reset();
    for (k = 0; k < 80 && !(instr_valid && !imem_req && req_log.size() >= 4); k++)
      @(negedge clk);
    check("t2_fill_timeout", 64'(k < 80), 64'd1);
    repeat (3) @(negedge clk);
    check("t2_req_off",   64'(imem_req), 64'd0);
    check("t2_log_size",  64'(req_log.size()), 64'd4);
    check("t2_log3",      req_log[3], 64'hC);
    check("t2_head_pc",   instr_pc, 64'h0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("t2_head_pc_after_pop", instr_pc, 64'h4);
    check("t2_still_idle", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("t2_refetch_req",  64'(imem_req), 64'd1);
    check("t2_refetch_addr", imem_addr, 64'h10);

    // 3: redirect while waiting on 0x8
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    for (k = 0; k < 80 && !(imem_req && imem_addr == 64'h8); k++) @(negedge clk);
    check("t3_reach_8", 64'(k < 80), 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    redirect = 1'b0;
    check("t3_flushed",  64'(instr_valid), 64'd0);
    check("t3_hold_addr", imem_addr, 64'h8);
    L = req_log.size();
    for (k = 0; k < 40 && req_log.size() <= L; k++) @(negedge clk);
    check("t3_next_req", (req_log.size() > L) ? req_log[L] : 64'hFFFF, 64'h100);
    for (k = 0; k < 40 && !instr_valid; k++) @(negedge clk);
    check("t3_first_pc",   instr_pc, 64'h100);
    check("t3_first_word", 64'(instruction), 64'h0100_FEFF);

    // 4: redirect coincides with ack and pop
    lat = 0;
    do_reset();
    instr_ready = 1'b1;
    for (k = 0; k < 20 && !(instr_valid && imem_req); k++) @(negedge clk);
    check("t4_busy", 64'(k < 20), 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h400;
    @(negedge clk);
    redirect = 1'b0;
    check("t4_empty", 64'(instr_valid), 64'd0);
    check("t4_idle",  64'(imem_req), 64'd0);
    @(negedge clk);
    check("t4_req",  64'(imem_req), 64'd1);
    check("t4_addr", imem_addr, 64'h400);

    // 5: two redirects while the dropped request is pending
    lat = 4;
    do_reset();
    instr_ready = 1'b1;
    for (k = 0; k < 20 && !imem_req; k++) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    redirect_pc = 64'h300;
    @(negedge clk);
    redirect = 1'b0;
    check("t5_drop_addr", imem_addr, 64'h0);
    L = req_log.size();
    for (k = 0; k < 40 && req_log.size() <= L; k++) @(negedge clk);
    check("t5_next_req", (req_log.size() > L) ? req_log[L] : 64'hFFFF, 64'h300);
    for (k = 0; k < 40 && !instr_valid; k++) @(negedge clk);
    check("t5_first_pc", instr_pc, 64'h300);

    // 6: asynchronous reset mid-request with three words buffered
    lat = 1;
    do_reset();
    for (k = 0; k < 40 && !(mq.size() == 3 && imem_req); k++) @(negedge clk);
    check("t6_three", 64'(instr_pc == 64'h0 && imem_addr == 64'hC), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_req0",   64'(imem_req), 64'd0);
    check("t6_addr0",  imem_addr, 64'h0);
    check("t6_valid0", 64'(instr_valid), 64'd0);
    check("t6_instr0", 64'(instruction), 64'h0);
    check("t6_pc0",    instr_pc, 64'h0);
    @(negedge clk);
    req_log.delete();
    reset = 1'b0;
    @(negedge clk);
    check("t6_restart_req",  64'(imem_req), 64'd1);
    check("t6_restart_addr", imem_addr, 64'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
